// File: rtl/keypad_pkg.sv
// keypad_pkg: key-code constants, digit check and entry FSM states shared by the keypad blocks
package keypad_pkg;
    localparam logic [3:0] KEY_ENTER = 4'hF;
    localparam logic [3:0] KEY_BACK  = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hD;

    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} entry_state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction
endpackage

// File: rtl/pin_entry_buffer_if.sv
// pin_entry_buffer_if: key strobes in, completed code out over valid/ready
interface pin_entry_buffer_if #(parameter int MAX_DIGITS = 8);
    logic [3:0]              key_value;
    logic                    key_valid;
    logic                    code_ready;
    logic [4*MAX_DIGITS-1:0] code_digits;
    logic [3:0]              code_len;
    logic                    code_valid;
    logic                    entry_active;
    logic                    entry_timeout;
    logic                    entry_error;

    modport master (
        output key_value, key_valid, code_ready,
        input  code_digits, code_len, code_valid, entry_active, entry_timeout, entry_error
    );
    modport slave (
        input  key_value, key_valid, code_ready,
        output code_digits, code_len, code_valid, entry_active, entry_timeout, entry_error
    );
endinterface

// File: rtl/inactivity_timer.sv
// inactivity_timer: counts idle enabled cycles and pulses expire on the TIMEOUT_CYCLES-th one
module inactivity_timer #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    // a restart in the expiry cycle suppresses the pulse
    assign expire = enable && !restart && cnt == W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else       cnt <= (!enable || restart || expire) ? '0 : cnt + W'(1);
endmodule

// File: rtl/pin_entry_buffer.sv
// pin_entry_buffer: assembles keypad digits into a PIN and hands it off on enter
module pin_entry_buffer
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS     = 8,
    parameter int MIN_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input logic              clk,
    input logic              reset,
    pin_entry_buffer_if.slave bus
);
    localparam int BW = 4*MAX_DIGITS;

    entry_state_t state;
    logic         key_acc;
    logic         expire;

    // A-C are dead keys: they neither act nor count as activity
    assign key_acc = bus.key_valid && (is_digit(bus.key_value) || bus.key_value >= KEY_CLEAR);

    assign bus.code_valid   = state == PRESENT;
    assign bus.entry_active = state == COLLECT;

    inactivity_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .enable  (state == COLLECT),
        .restart (state == COLLECT && key_acc),
        .expire  (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            bus.code_digits   <= '0;
            bus.code_len      <= '0;
            bus.entry_error   <= 1'b0;
            bus.entry_timeout <= 1'b0;
        end else begin
            bus.entry_error   <= 1'b0;
            bus.entry_timeout <= 1'b0;
            unique case (state)
                IDLE:
                    if (key_acc && is_digit(bus.key_value)) begin
                        bus.code_digits <= BW'(bus.key_value);
                        bus.code_len    <= 4'd1;
                        state           <= COLLECT;
                    end else if (key_acc && bus.key_value == KEY_ENTER) begin
                        bus.entry_error <= 1'b1;
                    end
                COLLECT:
                    if (key_acc && is_digit(bus.key_value)) begin
                        if (bus.code_len < 4'(MAX_DIGITS)) begin
                            bus.code_digits <= (bus.code_digits << 4) | BW'(bus.key_value);
                            bus.code_len    <= bus.code_len + 4'd1;
                        end else begin
                            bus.entry_error <= 1'b1;
                        end
                    end else if (key_acc && bus.key_value == KEY_BACK) begin
                        bus.code_digits <= bus.code_digits >> 4;
                        bus.code_len    <= bus.code_len - 4'd1;
                        if (bus.code_len == 4'd1) state <= IDLE;
                    end else if (key_acc && bus.key_value == KEY_ENTER && bus.code_len >= 4'(MIN_DIGITS)) begin
                        state <= PRESENT;
                    end else if (key_acc || expire) begin
                        bus.entry_error   <= key_acc && bus.key_value == KEY_ENTER;
                        bus.entry_timeout <= !key_acc;
                        bus.code_digits   <= '0;
                        bus.code_len      <= '0;
                        state             <= IDLE;
                    end
                PRESENT:
                    if (bus.code_ready) begin
                        bus.code_digits <= '0;
                        bus.code_len    <= '0;
                        state           <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pin_entry_buffer.sv
// tb_pin_entry_buffer: directed key sequences with hand-computed expectations
module tb_pin_entry_buffer;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pin_entry_buffer_if #(.MAX_DIGITS(8)) bus ();

    pin_entry_buffer #(.MAX_DIGITS(8), .MIN_DIGITS(4), .TIMEOUT_CYCLES(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] v);
        bus.key_value = v;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_digits"}, bus.code_digits, 32'h0);
        chk({tag, "_len"}, 32'(bus.code_len), 32'h0);
        chk({tag, "_flags"}, {28'h0, bus.code_valid, bus.entry_active, bus.entry_timeout, bus.entry_error}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.key_value = 4'h0;
        bus.key_valid = 1'b0;
        bus.code_ready = 1'b0;
        idle(2);
        all_zero("reset");
        reset = 1'b0;

        key(4'hF);
        chk("idle_enter_err", 32'(bus.entry_error), 32'h1);
        chk("idle_enter_len", 32'(bus.code_len), 32'h0);

        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        chk("t1_active", 32'(bus.entry_active), 32'h1);
        key(4'hF);
        chk("t1_valid", 32'(bus.code_valid), 32'h1);
        chk("t1_digits", bus.code_digits, 32'h1234);
        chk("t1_len", 32'(bus.code_len), 32'h4);
        idle(5);
        chk("t1_hold", 32'(bus.code_valid), 32'h1);
        bus.code_ready = 1'b1;
        idle(1);
        bus.code_ready = 1'b0;
        all_zero("t1_done");

        key(4'h5); key(4'h6); key(4'h7); key(4'hE); key(4'h8);
        chk("t2_digits", bus.code_digits, 32'h568);
        chk("t2_len", 32'(bus.code_len), 32'h3);
        key(4'hF);
        chk("t2_err", 32'(bus.entry_error), 32'h1);
        chk("t2_len0", 32'(bus.code_len), 32'h0);
        chk("t2_valid", 32'(bus.code_valid), 32'h0);
        idle(1);
        chk("t2_err_drop", 32'(bus.entry_error), 32'h0);

        for (int i = 1; i <= 8; i++) key(4'(i));
        chk("t3_len", 32'(bus.code_len), 32'h8);
        chk("t3_digits", bus.code_digits, 32'h12345678);
        key(4'h9);
        chk("t3_ovf_err", 32'(bus.entry_error), 32'h1);
        chk("t3_ovf_digits", bus.code_digits, 32'h12345678);
        key(4'hF);
        chk("t3_valid", 32'(bus.code_valid), 32'h1);
        chk("t3_present_digits", bus.code_digits, 32'h12345678);
        bus.code_ready = 1'b1;
        idle(1);
        bus.code_ready = 1'b0;
        chk("t3_done_len", 32'(bus.code_len), 32'h0);

        key(4'h4); key(4'h2);
        idle(19);
        chk("t4_pre_tmo", 32'(bus.entry_timeout), 32'h0);
        chk("t4_pre_len", 32'(bus.code_len), 32'h2);
        idle(1);
        chk("t4_tmo", 32'(bus.entry_timeout), 32'h1);
        chk("t4_len", 32'(bus.code_len), 32'h0);
        chk("t4_active", 32'(bus.entry_active), 32'h0);
        idle(1);
        chk("t4_tmo_drop", 32'(bus.entry_timeout), 32'h0);

        key(4'h4); key(4'h2);
        idle(19);
        key(4'h3);
        chk("t4b_tmo", 32'(bus.entry_timeout), 32'h0);
        chk("t4b_len", 32'(bus.code_len), 32'h3);
        chk("t4b_digits", bus.code_digits, 32'h423);
        key(4'hD);
        chk("t4b_clear_len", 32'(bus.code_len), 32'h0);
        chk("t4b_clear_active", 32'(bus.entry_active), 32'h0);

        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hF);
        key(4'h7); key(4'hD);
        chk("t5_digits", bus.code_digits, 32'h1234);
        chk("t5_valid", 32'(bus.code_valid), 32'h1);
        #2 reset = 1'b1;
        #1 all_zero("t5_reset");
        idle(1);
        reset = 1'b0;

        key(4'hA); key(4'hB); key(4'hC);
        chk("t6_idle_len", 32'(bus.code_len), 32'h0);
        chk("t6_idle_active", 32'(bus.entry_active), 32'h0);
        key(4'h5); key(4'hA); key(4'hB); key(4'hC);
        chk("t6_col_len", 32'(bus.code_len), 32'h1);
        chk("t6_col_digits", bus.code_digits, 32'h5);
        idle(16);
        chk("t6_pre_tmo", 32'(bus.entry_timeout), 32'h0);
        idle(1);
        chk("t6_tmo", 32'(bus.entry_timeout), 32'h1);
        chk("t6_len", 32'(bus.code_len), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pin_entry_buffer.md
Name: pin_entry_buffer

Overview:
- Sits directly downstream of the keypad matrix decoder and consumes its one-cycle key strobes.
- Assembles digit keys into a PIN buffer and supports backspace, clear and enter.
- Applies an inactivity timeout to partial entries.
- On enter, presents the completed code to the door-lock controller through a valid/ready handshake.

Parameters:
- MAX_DIGITS, 8: buffer capacity in digits (1..15).
- MIN_DIGITS, 4: minimum digits accepted on enter (1..MAX_DIGITS).
- TIMEOUT_CYCLES, 5000: idle cycles in COLLECT before the partial entry is discarded (>=2).

Ports:
- clk, input, 1: clock clk.
- reset, input, 1: reset reset, asynchronous, active-high.
- key_value, input, 4: key code from the decoder.
- key_valid, input, 1: one-cycle strobe; key_value is valid in that cycle.
- code_ready, input, 1: consumer accepts the presented code.
- code_digits, output, 4*MAX_DIGITS: BCD buffer; last-entered digit in nibble 0, unused upper nibbles 0.
- code_len, output, 4: number of digits held.
- code_valid, output, 1: completed code presented.
- entry_active, output, 1: high in COLLECT.
- entry_timeout, output, 1: one-cycle pulse when the entry is discarded by timeout.
- entry_error, output, 1: one-cycle pulse on overflow digit or short enter.

Behaviour:
- Reset (async): state IDLE, buffer 0, code_len 0, timer 0. All outputs 0.
- Key classes:
  - 0x0-0x9: digit.
  - 0xE: backspace.
  - 0xD: clear.
  - 0xF: enter.
  - 0xA, 0xB, 0xC: ignored, with no state change and no timer restart.
- Key events are sampled only when key_valid=1. An event at edge n is visible on outputs after edge n (latency 1).
- code_digits and code_len always mirror the live buffer. They are stable throughout PRESENT.
- States:
  - IDLE: buffer empty.
  - COLLECT: 1..MAX_DIGITS digits held.
  - PRESENT: code_valid=1.
- IDLE:
  - digit: buffer = digit, len 1, timer 0, go to COLLECT.
  - enter: pulse entry_error (len 0 < MIN_DIGITS), stay in IDLE.
  - backspace and clear: no effect.
- COLLECT, digit:
  - len < MAX_DIGITS: buffer = (buffer << 4) | digit, len+1, timer 0.
  - len == MAX_DIGITS: digit discarded, entry_error pulse, buffer unchanged, timer 0.
- COLLECT, backspace: buffer >> 4, len-1, timer 0. If the new len is 0, go to IDLE.
- COLLECT, clear: buffer 0, len 0, go to IDLE, no pulse.
- COLLECT, enter:
  - len >= MIN_DIGITS: go to PRESENT, code_valid=1 from the next cycle.
  - otherwise: entry_error pulse, buffer cleared, go to IDLE.
- COLLECT, timeout:
  - Timer increments every cycle with no accepted key.
  - When the timer reaches TIMEOUT_CYCLES-1 with no key that cycle: entry_timeout pulse, buffer cleared, go to IDLE.
  - A key in the expiry cycle wins: it is processed normally and the timer restarts.
- PRESENT:
  - code_valid held high; all key strobes dropped; timer frozen at 0.
  - On code_valid & code_ready: the next cycle has code_valid 0, buffer 0, len 0, state IDLE.
  - code_ready while not PRESENT is ignored.
- Pulse outputs are never high simultaneously. entry_timeout and entry_error are never asserted in PRESENT.
- Reset mid-entry or in PRESENT: immediate return to the reset values; the pending code is lost.
- entry_active = (state == COLLECT).

Decomposition:
- Shared package keypad_pkg:
  - Key-code constants KEY_ENTER=4'hF, KEY_BACK=4'hE, KEY_CLEAR=4'hD.
  - Digit-range check function is_digit().
  - State enum entry_state_t {IDLE, COLLECT, PRESENT}.
- One sub-module: inactivity_timer.
  - Parameter TIMEOUT_CYCLES.
  - Inputs: clk, reset, enable, restart.
  - Output: expire (one-cycle pulse).
- Buffer shift logic and the FSM live in pin_entry_buffer.

Test Plan:
- Keys 1,2,3,4 then F, code_ready=0 for 5 cycles then 1 → code_valid high 1 cycle after F, code_digits[15:0]=16'h1234, code_len=4. After the ready cycle: code_valid=0, len=0.
- Keys 5,6,7,E,8,F → code_digits[15:0]=16'h0568, len 3, entry_error pulse on F, buffer cleared, code_valid stays 0.
- 9 digits 1..9 with MAX_DIGITS=8 → len 8, code_digits=32'h12345678, entry_error pulse on the 9th key. Then F → code_valid=1 with the same value.
- TIMEOUT_CYCLES=20, keys 4,2 then idle → entry_timeout pulse exactly 20 cycles after key 2, then len 0 and entry_active=0. The same sequence with key 3 arriving on the expiry cycle → no pulse, len 3.
- In PRESENT, inject key strobes 7 and D → code_digits unchanged and code_valid held. Assert reset mid-PRESENT → all outputs 0 immediately.
- Keys A,B,C in IDLE and COLLECT → no change to len or state; the timeout still expires on schedule from the last digit.
